// File: rtl/clk_rst_pkg.sv
// Shared types and sizing helpers for the MMCM reset/lock supervisor.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    RST_MMCM  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } clk_rst_state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // One spare bit so a counter can hold its terminal value without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/clk_rst_ctrl_if.sv
// Status/control bundle between the supervisor and its surroundings.
interface clk_rst_ctrl_if;
  import clk_rst_pkg::*;

  // soft_rst is a one-cycle request sampled on sys_clk; there is no ready,
  // the supervisor accepts it in every state. locked may change at any time.
  logic               locked;
  logic               soft_rst;
  logic               mmcm_rst;
  logic               user_rst_n;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOSS_W-1:0]  lock_loss_cnt;
  clk_rst_state_t     state;

  modport master (
    output locked, soft_rst,
    input  mmcm_rst, user_rst_n, fail, retry_cnt, lock_loss_cnt, state
  );

  modport slave (
    input  locked, soft_rst,
    output mmcm_rst, user_rst_n, fail, retry_cnt, lock_loss_cnt, state
  );

endinterface

// File: rtl/clk_rst_ctrl_sync_2ff.sv
// Two-flop synchronizer for asynchronous level/status inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_ctrl.sv
// MMCM reset/lock supervisor: pulses mmcm_rst, waits for a stable lock and
// then releases the fabric reset; retries on timeout and parks in FAIL.
module clk_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRIES     = 4
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  clk_rst_ctrl_if.slave bus
);

  // One shared timer, sized for the longest phase; it restarts on every entry.
  localparam int W_RST = cnt_w(MMCM_RST_CYCLES);
  localparam int W_TMO = cnt_w(LOCK_TIMEOUT);
  localparam int W_STB = cnt_w(STABLE_CYCLES);
  localparam int W_AB  = (W_RST > W_TMO) ? W_RST : W_TMO;
  localparam int TMR_W = (W_AB > W_STB) ? W_AB : W_STB;

  localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(MMCM_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMO_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   STB_LAST    = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE     = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = {{(RETRY_W-1){1'b0}}, 1'b1};
  localparam logic [LOSS_W-1:0]  LOSS_ONE    = {{(LOSS_W-1){1'b0}}, 1'b1};

  clk_rst_state_t     state_q, state_nxt;
  logic [TMR_W-1:0]   timer_q, timer_nxt;
  logic [RETRY_W-1:0] retry_q, retry_nxt, retry_inc;
  logic [LOSS_W-1:0]  loss_q, loss_nxt;
  logic               mmcm_rst_q, mmcm_rst_nxt;
  logic               user_rst_n_q, user_rst_n_nxt;
  logic               fail_q, fail_nxt;
  logic               locked_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (bus.locked),
    .q     (locked_s)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_MMCM;
      timer_q      <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      mmcm_rst_q   <= 1'b1;
      user_rst_n_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      timer_q      <= timer_nxt;
      retry_q      <= retry_nxt;
      loss_q       <= loss_nxt;
      mmcm_rst_q   <= mmcm_rst_nxt;
      user_rst_n_q <= user_rst_n_nxt;
      fail_q       <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    retry_nxt = retry_q;
    loss_nxt  = loss_q;
    retry_inc = retry_q + RETRY_ONE;
    if (bus.soft_rst) begin
      state_nxt = RST_MMCM;
      retry_nxt = '0;
    end else begin
      case (state_q)
        RST_MMCM: begin
          if (timer_q == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // A lock seen in the timeout cycle still counts as a lock.
          if (locked_s) begin
            state_nxt = STABLE;
          end else if (timer_q == TMO_LAST) begin
            retry_nxt = retry_inc;
            state_nxt = (retry_inc == RETRY_LIMIT) ? FAIL : RST_MMCM;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
          end else if (timer_q == STB_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = RST_MMCM;
            if (loss_q != '1) loss_nxt = loss_q + LOSS_ONE;
          end
        end
        FAIL:    state_nxt = FAIL;
        default: state_nxt = RST_MMCM;
      endcase
    end

    if (bus.soft_rst || (state_nxt != state_q)) begin
      timer_nxt = '0;
    end else if (state_q inside {RST_MMCM, WAIT_LOCK, STABLE}) begin
      timer_nxt = timer_q + TMR_ONE;
    end else begin
      timer_nxt = timer_q;
    end
  end

  // Outputs follow the next state so they switch on the same edge as the state.
  always_comb begin
    mmcm_rst_nxt   = 1'b0;
    user_rst_n_nxt = 1'b0;
    fail_nxt       = 1'b0;
    case (state_nxt)
      RST_MMCM: mmcm_rst_nxt = 1'b1;
      RUN:      user_rst_n_nxt = 1'b1;
      FAIL: begin
        mmcm_rst_nxt = 1'b1;
        fail_nxt     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mmcm_rst      = mmcm_rst_q;
  assign bus.user_rst_n    = user_rst_n_q;
  assign bus.fail          = fail_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.lock_loss_cnt = loss_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Self-checking bench for clk_rst_ctrl; outputs packed as
// {mmcm_rst, user_rst_n, fail, retry_cnt, lock_loss_cnt}, checked after each edge.
module tb_clk_rst_ctrl;
  import clk_rst_pkg::*;

  localparam int R = 4;
  localparam int T = 100;
  localparam int S = 8;
  localparam int M = 3;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_loss = 8'd0;

  clk_rst_ctrl_if bus ();

  clk_rst_ctrl #(
    .MMCM_RST_CYCLES (R),
    .LOCK_TIMEOUT    (T),
    .STABLE_CYCLES   (S),
    .MAX_RETRIES     (M)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [14:0] pack(input logic mr, input logic ur, input logic fl,
                                       input logic [3:0] rc, input logic [7:0] lc);
    return {mr, ur, fl, rc, lc};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.mmcm_rst, bus.user_rst_n, bus.fail, bus.retry_cnt, bus.lock_loss_cnt};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Reset is released on a falling edge; the next rising edge is edge 1.
  task automatic do_reset(input logic lk);
    rst_n        = 1'b0;
    bus.locked   = lk;
    bus.soft_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n    = 1'b1;
    exp_loss = 8'd0;
  endtask

  task automatic test_reset();
    logic [14:0] e;
    bus.locked   = 1'b0;
    bus.soft_rst = 1'b0;
    rst_n        = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: got %h want %h", i, obs(), e);
      end
      checks++;
      if (bus.state !== RST_MMCM) begin
        errors++;
        $display("FAIL reset_state cyc %0d: got %0d want %0d", i, bus.state, RST_MMCM);
      end
    end
  endtask

  // locked rises before edge 10; synchronized at edge 11, STABLE at 12, RUN at 12+S.
  task automatic test_nominal();
    logic [14:0] e;
    do_reset(1'b0);
    for (int k = 1; k <= 24; k++) begin
      exp_q.push_back(pack(k < R, k >= 12 + S, 1'b0, 4'd0, 8'd0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL nominal edge %0d: got %h want %h", k, obs(), e);
      end
      if (k == 9) bus.locked = 1'b1;
    end
  endtask

  // One-cycle dropout sampled at edge 15: back to WAIT_LOCK at 17, STABLE at 18, RUN at 18+S.
  task automatic test_glitch();
    logic [14:0] e;
    do_reset(1'b0);
    for (int k = 1; k <= 30; k++) begin
      exp_q.push_back(pack(k < R, k >= 18 + S, 1'b0, 4'd0, 8'd0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL glitch edge %0d: got %h want %h", k, obs(), e);
      end
      if (k == 9)  bus.locked = 1'b1;
      if (k == 14) bus.locked = 1'b0;
      if (k == 15) bus.locked = 1'b1;
    end
  endtask

  task automatic test_timeout_fail();
    logic [14:0] e;
    logic [3:0]  rc;
    logic        mr;
    int          to;
    do_reset(1'b0);
    for (int k = 1; k <= 320; k++) begin
      rc = 4'd0;
      mr = (k < R);
      for (int a = 0; a < M; a++) begin
        to = R + a * (R + T) + T;
        if (k >= to) rc = rc + 4'd1;
        if (k >= to && k < to + R) mr = 1'b1;
      end
      if (rc == 4'(M)) mr = 1'b1;
      exp_q.push_back(pack(mr, 1'b0, rc == 4'(M), rc, 8'd0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL timeout edge %0d: got %h want %h", k, obs(), e);
      end
      if (k == 314) bus.locked = 1'b1;
      if (k == 318) bus.locked = 1'b0;
    end
  endtask

  // soft_rst at j=0 leaves FAIL; at j=208 it collides with the second timeout.
  task automatic test_soft_rst();
    logic [14:0] e;
    logic [3:0]  rc;
    logic        mr;
    for (int j = 0; j <= 215; j++) begin
      bus.soft_rst = (j == 0) || (j == 2 * T + R + R);
      rc = (j >= R + T && j < 2 * T + 2 * R) ? 4'd1 : 4'd0;
      mr = (j < R) || (j >= R + T && j < 2 * R + T) || (j >= 2 * T + 2 * R && j < 2 * T + 3 * R);
      exp_q.push_back(pack(mr, 1'b0, 1'b0, rc, exp_loss));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL soft_rst step %0d: got %h want %h", j, obs(), e);
      end
    end
    bus.soft_rst = 1'b0;
  endtask

  // Drop to RST_MMCM 3 edges after locked falls, relock, RUN again 16 edges after the drop.
  task automatic test_lock_loss();
    logic [14:0] e;
    logic [7:0]  nxt_loss;
    do_reset(1'b1);
    for (int k = 1; k <= 14; k++) begin
      exp_q.push_back(pack(k < R, k >= 13, 1'b0, 4'd0, 8'd0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lock_loss startup edge %0d: got %h want %h", k, obs(), e);
      end
    end
    for (int n = 1; n <= 300; n++) begin
      nxt_loss   = (exp_loss == 8'd255) ? 8'd255 : exp_loss + 8'd1;
      bus.locked = 1'b0;
      for (int j = 1; j <= 16; j++) begin
        exp_q.push_back(pack(j >= 3 && j < 3 + R, j < 3 || j >= 16, 1'b0, 4'd0,
                             (j >= 3) ? nxt_loss : exp_loss));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL lock_loss iter %0d step %0d: got %h want %h", n, j, obs(), e);
        end
        if (j == 3) bus.locked = 1'b1;
      end
      exp_loss = nxt_loss;
    end
    checks++;
    if (bus.lock_loss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL lock_loss_saturate: got %0d want 255", bus.lock_loss_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] e;
    bus.locked = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      exp_q.push_back(pack(j >= 3 && j < 3 + R, j < 3, 1'b0, 4'd0, exp_loss));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL async_prep step %0d: got %h want %h", j, obs(), e);
      end
      if (j == 3) bus.locked = 1'b1;
    end
    checks++;
    if (bus.state !== STABLE) begin
      errors++;
      $display("FAIL async_in_stable: got state %0d want %0d", bus.state, STABLE);
    end
    rst_n = 1'b0;
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h want %h", obs(), e);
    end
    checks++;
    if (bus.state !== RST_MMCM) begin
      errors++;
      $display("FAIL async_reset_state: got %0d want %0d", bus.state, RST_MMCM);
    end
  endtask

  initial begin
    bus.locked   = 1'b0;
    bus.soft_rst = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout_fail();
    test_soft_rst();
    test_lock_loss();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_rst_ctrl.md
# clk_rst_ctrl

Reset and lock supervisor for the MMCM clock module. It drives the MMCM `RST` input, watches the asynchronous `locked` output, and releases the fabric reset only after lock has been stable for a programmed time. It retries the MMCM on lock timeout and flags a hard failure after repeated timeouts. It runs on the free-running board clock (post-IBUFGDS), never on an MMCM output, so it keeps working while the MMCM is held in reset.

## Interface
Parameters:
- `MMCM_RST_CYCLES`, 16: cycles `mmcm_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, 4: timeouts tolerated before FAIL (1..15).

Ports:
- `sys_clk` in 1: free-running board clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: MMCM lock, asynchronous to `sys_clk`.
- `soft_rst` in 1: synchronous, single-cycle restart request.
- `mmcm_rst` out 1: MMCM reset, active high.
- `user_rst_n` out 1: fabric reset, active low; high only in RUN.
- `fail` out 1: high in FAIL.
- `retry_cnt` out 4: timeouts since the last entry to RUN or restart.
- `lock_loss_cnt` out 8: lock drops seen in RUN; saturates at 255.

## Operation
- `locked` passes through a 2-FF synchronizer to give `locked_s`. It has 2 cycles of latency and is the only use of `locked`.
- States: RST_MMCM, WAIT_LOCK, STABLE, RUN, FAIL.
- RST_MMCM: `mmcm_rst`=1. Stays exactly `MMCM_RST_CYCLES` cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: `mmcm_rst`=0 and the timer runs.
  - `locked_s`=1 → STABLE.
  - Timer reaches `LOCK_TIMEOUT` with no lock → `retry_cnt`+1.
    - If the new value equals `MAX_RETRIES` → FAIL.
    - Otherwise → RST_MMCM.
  - Lock wins over timeout in the same cycle.
- STABLE: counts consecutive `locked_s`=1 cycles.
  - `locked_s`=0 → WAIT_LOCK. The timeout timer restarts from 0 and no retry is counted.
  - Count reaches `STABLE_CYCLES` → RUN; `retry_cnt` clears on entry.
- RUN: `user_rst_n`=1.
  - `locked_s`=0 → `lock_loss_cnt`+1 (saturating) and → RST_MMCM.
- FAIL: `mmcm_rst`=1, `user_rst_n`=0, `fail`=1. Held until `soft_rst` or `rst_n`.
- `soft_rst`=1 in any state → RST_MMCM next cycle, with `retry_cnt` cleared. It has priority over every other transition in the same cycle. `lock_loss_cnt` is kept; only `rst_n` clears it.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.

## Timing
- Reset values:
  - state=RST_MMCM
  - `mmcm_rst`=1
  - `user_rst_n`=0
  - `fail`=0
  - `retry_cnt`=0
  - `lock_loss_cnt`=0
  - synchronizer flops=0
  - all counters=0
- Reset deassertion: the first edge with `rst_n` high is cycle 1 of RST_MMCM.
- Best case from `rst_n` release to `user_rst_n` high: `MMCM_RST_CYCLES` + 2 (sync) + 1 (WAIT_LOCK→STABLE) + `STABLE_CYCLES` cycles.
- Lock drop in RUN: `user_rst_n` falls 3 edges after `locked` falls (2 sync + 1 state). `mmcm_rst` rises on the same edge.
- Counter widths are $clog2 of the parameter +1. A counter never wraps; it is cleared on every state entry.
- `rst_n` assertion mid-operation forces reset values immediately (asynchronous), including in FAIL.

## Structure
- Package `clk_rst_pkg` holds:
  - the state enum `clk_rst_state_t`
  - the `RETRY_W`=4 and `LOSS_W`=8 constants
  - a `cnt_w(n)` width function
- Sub-module `sync_2ff` (parameterized width, async active-low reset to 0) synchronizes `locked`. It is reusable for other async status inputs.
- The FSM, counters and output registers sit in `clk_rst_ctrl`.

## Test plan
Bench parameters: `MMCM_RST_CYCLES`=4, `LOCK_TIMEOUT`=100, `STABLE_CYCLES`=8, `MAX_RETRIES`=3.

- **Nominal lock:** release `rst_n`, raise `locked` on cycle 10 → `mmcm_rst` high cycles 1–4; `user_rst_n` rises on cycle 21; `retry_cnt`=0.
- **Glitch in STABLE:** `locked` high 5 cycles, low 1, then high → no RUN until 8 uninterrupted synchronized cycles; `retry_cnt` stays 0.
- **Timeout to FAIL:** `locked` held low → 3 RST_MMCM pulses of 4 cycles each, separated by 100-cycle waits; `fail`=1 after the third timeout; `mmcm_rst` stays high; `retry_cnt`=3.
- **Lock loss in RUN:** drop `locked` → `user_rst_n` low 3 edges later, `mmcm_rst` high, `lock_loss_cnt`=1. Relock → RUN again. Repeat 300 times → `lock_loss_cnt`=255.
- **soft_rst priority:** pulse `soft_rst` in FAIL and on the same cycle as a WAIT_LOCK timeout → RST_MMCM next cycle, `retry_cnt`=0, `fail`=0.
- **Async reset mid-STABLE:** assert `rst_n` low → all outputs at reset values before the next `sys_clk` edge.
